// File: rtl/cache_responder.sv
// Direct-mapped write-through one-word-line cache between the CPU and sync RAM.
// Define CACHE_RESPONDER_STATS_EN to build the saturating read hit/miss counters.
module cache_responder #(
    parameter int ADDR_WIDTH = 24,
    parameter int DATA_WIDTH = 32,
    parameter int LINES      = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_busy,
    output logic                  cpu_ready,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_hit,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [15:0]           stat_hits,
    output logic [15:0]           stat_misses
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOOKUP   = 3'd1;
    localparam logic [2:0] S_MEM_RD   = 3'd2;
    localparam logic [2:0] S_MEM_WAIT = 3'd3;
    localparam logic [2:0] S_MEM_WR   = 3'd4;
    localparam logic [2:0] S_RESP     = 3'd5;

    logic [2:0]            state_q, state_d;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  hit_q;
    logic [DATA_WIDTH-1:0] rbuf_q;

    logic [LINES-1:0]      valid_q;
    logic [TAG_W-1:0]      tag_q  [LINES];
    logic [DATA_WIDTH-1:0] data_q [LINES];

    logic                  ready_q, rhit_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] maddr_q;
    logic [DATA_WIDTH-1:0] mwdata_q;
    logic                  mcs_q, mwe_q, moe_q;

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] req_tag;
    logic             lookup_hit;

    assign idx        = addr_q[IDX_W-1:0];
    assign req_tag    = addr_q[ADDR_WIDTH-1:IDX_W];
    assign lookup_hit = valid_q[idx] && (tag_q[idx] == req_tag);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:     if (cpu_req) state_d = S_LOOKUP;
            S_LOOKUP: begin
                if (we_q)            state_d = S_MEM_WR;
                else if (lookup_hit) state_d = S_RESP;
                else                 state_d = S_MEM_RD;
            end
            S_MEM_RD:   state_d = S_MEM_WAIT;
            S_MEM_WAIT: state_d = S_RESP;
            S_MEM_WR:   state_d = S_RESP;
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            hit_q    <= 1'b0;
            rbuf_q   <= '0;
            valid_q  <= '0;
            ready_q  <= 1'b0;
            rhit_q   <= 1'b0;
            rdata_q  <= '0;
            maddr_q  <= '0;
            mwdata_q <= '0;
            mcs_q    <= 1'b0;
            mwe_q    <= 1'b0;
            moe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            // Completion is registered off RESP so the pulse lands in IDLE.
            ready_q <= (state_q == S_RESP);
            rhit_q  <= (state_q == S_RESP) && hit_q;
            if (state_q == S_RESP && !we_q) rdata_q <= rbuf_q;

            mcs_q <= (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
            moe_q <= (state_d == S_MEM_RD);
            mwe_q <= (state_d == S_MEM_WR);
            if (state_d == S_MEM_RD || state_d == S_MEM_WR) maddr_q <= addr_q;
            if (state_d == S_MEM_WR) mwdata_q <= wdata_q;

            if (state_q == S_IDLE && cpu_req) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
            end
            if (state_q == S_LOOKUP) begin
                hit_q <= lookup_hit;
                if (!we_q && lookup_hit) rbuf_q <= data_q[idx];
            end
            if (state_q == S_MEM_WAIT) begin
                valid_q[idx] <= 1'b1;
                rbuf_q       <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && state_q == S_MEM_WAIT) begin
            tag_q[idx]  <= req_tag;
            data_q[idx] <= mem_rdata;
        end else if (rst_n && state_q == S_MEM_WR && hit_q) begin
            data_q[idx] <= wdata_q;
        end
    end

`ifdef CACHE_RESPONDER_STATS_EN
    logic [15:0] hits_q, misses_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else if (state_q == S_LOOKUP && !we_q) begin
            if (lookup_hit && hits_q != 16'hFFFF)     hits_q   <= hits_q + 16'd1;
            if (!lookup_hit && misses_q != 16'hFFFF) misses_q <= misses_q + 16'd1;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;
`else
    assign stat_hits   = 16'd0;
    assign stat_misses = 16'd0;
`endif

    assign cpu_busy  = (state_q != S_IDLE);
    assign cpu_ready = ready_q;
    assign cpu_hit   = rhit_q;
    assign cpu_rdata = rdata_q;
    assign mem_addr  = maddr_q;
    assign mem_wdata = mwdata_q;
    assign mem_cs    = mcs_q;
    assign mem_we    = mwe_q;
    assign mem_oe    = moe_q;

endmodule

// File: tb/tb_cache_responder.sv
// Randomized bench for cache_responder against a residency/golden-memory model.
// Stats expectations follow CACHE_RESPONDER_STATS_EN when it is defined.
module tb_cache_responder;

    localparam int AW = 24;
    localparam int DW = 32;
    localparam int NL = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_busy, cpu_ready, cpu_hit;
    logic [DW-1:0] cpu_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_cs, mem_we, mem_oe;
    logic [15:0]   stat_hits, stat_misses;

    cache_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINES(NL)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_busy(cpu_busy), .cpu_ready(cpu_ready),
        .cpu_rdata(cpu_rdata), .cpu_hit(cpu_hit),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_cs(mem_cs),
        .mem_we(mem_we), .mem_oe(mem_oe),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return 32'h1000_0000 + {8'h00, a} + 32'h1E;
    endfunction

    // RAM stand-in: one-cycle read latency
    logic [DW-1:0] ram [logic [AW-1:0]];
    int            nrd = 0, nwr = 0;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_wdata = '0;

    always @(posedge clk) begin
        if (mem_cs && mem_we) begin
            ram[mem_addr] = mem_wdata;
            nwr++;
        end else if (mem_cs && mem_oe) begin
            mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr]
                                              : init_word(mem_addr);
            nrd++;
        end
        if (mem_cs) begin
            last_addr  = mem_addr;
            last_wdata = mem_wdata;
        end
    end

    // Reference model: memory contents plus which address each line holds
    logic [DW-1:0] gold [logic [AW-1:0]];
    logic [AW-1:0] res_addr [NL];
    logic          res_ok [NL];
    int            exp_hits = 0, exp_misses = 0;

    function automatic logic [DW-1:0] gold_rd(input logic [AW-1:0] a);
        return gold.exists(a) ? gold[a] : init_word(a);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) res_ok[i] = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
    endtask

    task automatic do_req(input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input string nm);
        int            ix, lat, exp_lat;
        logic          exp_hit;
        logic [DW-1:0] exp_data;
        ix = int'(a[3:0]);
        exp_hit = res_ok[ix] && res_addr[ix] == a;
        exp_lat = we ? 3 : (exp_hit ? 2 : 4);
        exp_data = gold_rd(a);
        if (we) begin
            gold[a] = wd;
        end else begin
            if (exp_hit) exp_hits++;
            else exp_misses++;
            res_ok[ix] = 1'b1;
            res_addr[ix] = a;
        end
        @(negedge clk);
        nrd = 0;
        nwr = 0;
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = wd;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (cpu_ready) break;
        end
        check({nm, " latency"}, lat, exp_lat);
        check({nm, " hit"}, {31'd0, cpu_hit}, {31'd0, exp_hit});
        if (!we) check({nm, " rdata"}, cpu_rdata, exp_data);
        check({nm, " mem reads"}, nrd, (!we && !exp_hit) ? 1 : 0);
        check({nm, " mem writes"}, nwr, we ? 1 : 0);
        if (we || !exp_hit) check({nm, " mem addr"}, {8'h00, last_addr}, {8'h00, a});
        if (we) check({nm, " mem wdata"}, last_wdata, wd);
    endtask

    task automatic check_stats(input string nm);
`ifdef CACHE_RESPONDER_STATS_EN
        check({nm, " stat_hits"}, {16'd0, stat_hits}, exp_hits);
        check({nm, " stat_misses"}, {16'd0, stat_misses}, exp_misses);
`else
        check({nm, " stat_hits"}, {16'd0, stat_hits}, 0);
        check({nm, " stat_misses"}, {16'd0, stat_misses}, 0);
`endif
    endtask

    initial begin
        logic          saw_ready;
        logic [AW-1:0] a;
        model_reset();
        ram[24'h000100] = 32'h1000_011E;
        gold[24'h000100] = 32'h1000_011E;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst busy", {31'd0, cpu_busy}, 0);
        check("rst ready", {31'd0, cpu_ready}, 0);
        check("rst hit", {31'd0, cpu_hit}, 0);
        check("rst strobes", {29'd0, mem_cs, mem_we, mem_oe}, 0);
        check("rst rdata", cpu_rdata, 0);
        check("rst mem_addr", {8'h00, mem_addr}, 0);
        check("rst mem_wdata", mem_wdata, 0);
        check_stats("rst");

        do_req(1'b0, 24'h000100, '0, "rd100 miss");
        check("rd100 value", cpu_rdata, 32'h1000_011E);
        do_req(1'b0, 24'h000100, '0, "rd100 hit");
        do_req(1'b1, 24'h00011E, 32'h7, "wr11E");
        do_req(1'b0, 24'h00011E, '0, "rd11E");
        check("rd11E value", cpu_rdata, 32'h7);
        do_req(1'b1, 24'h000100, 32'hCAFE_0001, "wr100 hit");
        do_req(1'b0, 24'h000100, '0, "rd100 after wr");
        do_req(1'b0, 24'h000102, '0, "conf a");
        do_req(1'b0, 24'h000112, '0, "conf b");
        do_req(1'b0, 24'h000102, '0, "conf c");
        do_req(1'b0, 24'hFFFFFF, '0, "top miss");
        do_req(1'b0, 24'hFFFFFF, '0, "top hit");
        check_stats("directed");

        // Abort a miss while the fill is in flight
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 24'h000345;
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        nrd = 0;
        nwr = 0;
        saw_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (cpu_ready) saw_ready = 1'b1;
        end
        check("abort ready", {31'd0, saw_ready}, 0);
        check("abort mem cycles", nrd + nwr, 0);
        check("abort busy", {31'd0, cpu_busy}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        check_stats("abort");
        do_req(1'b0, 24'h000345, '0, "post-rst rd");
        do_req(1'b0, 24'h000100, '0, "post-rst rd100");

        for (int n = 0; n < 120; n++) begin
            if ($urandom_range(0, 15) == 0) a = 24'hFFFFFF;
            else a = 24'h000400 + 24'($urandom_range(0, 63));
            do_req($urandom_range(0, 2) == 0, a, $urandom, "rand");
        end
        check_stats("final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_responder.md
Name: cache_responder

Overview:
- Direct-mapped, write-through, word-addressed cache controller. It is the responder for the CPU's fetch/load/store requests.
- Sits between the CPU datapath (MAR/MBR side) and single_port_sync_ram_large.
- Serves read hits from internal lines and fills lines on read misses.
- Forwards every write to main memory and updates the line only on a hit (no write-allocate).
- Replaces the ad-hoc cwe/coe/found cache poking in the datapath with a req/ready handshake.

Parameters:
- ADDR_WIDTH, 24, word address width on both CPU and memory sides.
- DATA_WIDTH, 32, data word width.
- LINES, 16, number of one-word lines; power of 2, >= 2; IDX_W = log2(LINES).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- cpu_req  in  1  request strobe; sampled only in IDLE.
- cpu_we  in  1  1 = store, 0 = load/fetch; sampled with cpu_req.
- cpu_addr  in  ADDR_WIDTH  word address; sampled with cpu_req.
- cpu_wdata  in  DATA_WIDTH  store data; sampled with cpu_req.
- cpu_busy  out  1  high in every state except IDLE.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_WIDTH  load result; valid when cpu_ready=1 for a read, held until the next read completes.
- cpu_hit  out  1  lookup result of the completed request; valid with cpu_ready.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data; top level drives the tri-state bus when mem_oe=0.
- mem_rdata  in  DATA_WIDTH  RAM read data.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write enable.
- mem_oe  out  1  RAM output enable.
- stat_hits  out  16  read-hit counter (see Optional Feature).
- stat_misses  out  16  read-miss counter (see Optional Feature).

Behaviour:
- Address split: index = addr[IDX_W-1:0]; tag = addr[ADDR_WIDTH-1:IDX_W]. Each line holds valid, tag and data.
- Reset (rst_n=0 at a rising edge):
  - state is IDLE and all valid bits are 0.
  - cpu_busy, cpu_ready, cpu_hit, mem_cs, mem_we and mem_oe are 0.
  - cpu_rdata, mem_addr and mem_wdata are 0.
  - Stats counters are 0.
  - Reset mid-transaction aborts the transaction: no cpu_ready, no further memory cycle, and line contents are discarded via the valid clear.
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WAIT, MEM_WR, RESP.
- IDLE:
  - If cpu_req=1, latch we/addr/wdata and go to LOOKUP.
  - cpu_req while busy is ignored. The requester must hold its request until it sees cpu_busy=0.
- LOOKUP: hit = valid[idx] && tag[idx]==req_tag.
  - Read hit: go to RESP with rdata = line data.
  - Read miss: go to MEM_RD.
  - Write (hit or miss): go to MEM_WR.
- MEM_RD: mem_cs=1, mem_oe=1, mem_we=0, mem_addr=req_addr, for one cycle; then go to MEM_WAIT.
- MEM_WAIT:
  - Capture mem_rdata (RAM latency of 1).
  - Write the line: valid=1, tag, data. Set rdata = mem_rdata.
  - Go to RESP.
- MEM_WR:
  - mem_cs=1, mem_we=1, mem_oe=0, mem_addr=req_addr, mem_wdata=req_wdata, for one cycle.
  - If hit, the line data becomes req_wdata; on a miss the line is untouched.
  - Go to RESP.
- RESP: cpu_ready=1 and cpu_hit = the latched hit, for exactly one cycle; then go to IDLE.
- Completion latency, counted from the cpu_req sample edge: read hit 2 cycles, read miss 4 cycles, write 3 cycles. Back-to-back throughput is one request per (latency+1) cycles.
- Memory strobes are 0 in every state except MEM_RD and MEM_WR.
- Conflict miss: the new tag evicts the old one with no writeback; none is needed because the cache is write-through.
- Address wrap: no special case. Top-of-space 0xFFFFFF maps to index LINES-1.
- Write then read of the same address returns the new data: a hit if the line was resident, otherwise a fill from memory.

Optional Feature:
- Macro: CACHE_RESPONDER_STATS_EN.
- Defined:
  - stat_hits increments on each read hit.
  - stat_misses increments on each read miss.
  - Both update at the LOOKUP edge, saturate at 0xFFFF and clear on reset. Writes are not counted.
- Undefined: stat_hits and stat_misses are tied to 0, and no counter logic is compiled.

Test Plan:
- Reset, then read 0x000100 with RAM[0x100]=0x1000011E -> mem_cs/oe pulse at 0x100, cpu_ready 4 cycles after req, cpu_rdata=0x1000011E, cpu_hit=0.
- Repeat read 0x000100 -> cpu_ready 2 cycles after req, cpu_hit=1, no mem_cs activity, rdata=0x1000011E.
- Write 0x00011E data 0x00000007 (line not resident) -> one mem_cs/we cycle with addr 0x11E and wdata 0x7, ready after 3 cycles, cpu_hit=0. Then read 0x11E -> miss, returns 0x7.
- Read 0x000102, then read 0x000112 (same index 2, different tag), then read 0x000102 -> all three are misses with 3 memory reads, and the final data matches RAM[0x102].
- Assert rst_n=0 during MEM_WAIT of a miss, then read the same address -> no cpu_ready during reset, and the post-reset read is a miss.
- With CACHE_RESPONDER_STATS_EN: 2 misses + 3 hits + 1 write -> stat_misses=2, stat_hits=3. Without the macro both are 0.
